// File: rtl/set_idx_scan_ctrl_if.sv
// Mask-in / index-beat-out bundle for set_idx_scan_ctrl.
// The optional o_total_cnt signal exists only when SCAN_TOTAL_EN is defined.
interface set_idx_scan_ctrl_if;
  // Producer side
  logic         in_valid;
  logic [127:0] in_mask;
  logic         in_ready;
  logic         abort;
  // Consumer side
  logic         out_valid;
  logic         out_ready;
  logic [6:0]   out_idx1;
  logic [6:0]   out_idx2;
  logic [6:0]   out_idx3;
  logic [6:0]   out_idx4;
  logic [2:0]   out_cnt;
  logic         out_last;
  logic [4:0]   beat_num;
  logic         busy;
`ifdef SCAN_TOTAL_EN
  logic [7:0]   total_cnt;
`endif

  // Controller view
  modport slave (
    input  in_valid, in_mask, abort, out_ready,
    output in_ready, out_valid, out_idx1, out_idx2, out_idx3, out_idx4,
           out_cnt, out_last, beat_num, busy
`ifdef SCAN_TOTAL_EN
    , output total_cnt
`endif
  );

  // Producer/consumer view
  modport master (
    output in_valid, in_mask, abort, out_ready,
    input  in_ready, out_valid, out_idx1, out_idx2, out_idx3, out_idx4,
           out_cnt, out_last, beat_num, busy
`ifdef SCAN_TOTAL_EN
    , input total_cnt
`endif
  );
endinterface

// File: rtl/set_idx_scan_ctrl.sv
// set_idx_scan_ctrl: drains every set bit of a 128-bit mask as beats of up to
// four ascending indices. One mask is held at a time; beat fields come only
// from the remaining-bits register, so there is no input-to-output path.
// Optional feature macro: SCAN_TOTAL_EN adds a running handshaken-index count.
module set_idx_scan_ctrl #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned LANES  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  set_idx_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam int unsigned LaneW = $clog2(LANES);
  localparam int unsigned BeatW = $clog2(DATA_W / LANES);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   rem_q;
  logic [BeatW-1:0]    beat_q;
`ifdef SCAN_TOTAL_EN
  logic [7:0]          total_q;
`endif

  logic [IDX_W-1:0]    lane_idx [LANES];
  logic [CntW-1:0]     lane_cnt;
  logic [DATA_W-1:0]   found_mask;
  logic                scanning;
  logic                last_beat;

  // Four-lane lowest-set-bit finder over the remaining bits.
  always_comb begin
    lane_cnt   = '0;
    found_mask = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_idx[l] = '0;
    end
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (rem_q[i] && (lane_cnt < CntW'(LANES))) begin
        lane_idx[lane_cnt[LaneW-1:0]] = IDX_W'(i);
        found_mask[i]                 = 1'b1;
        lane_cnt                      = lane_cnt + CntW'(1);
      end
    end
  end

  assign scanning  = (state_q == StScan);
  assign last_beat = ((rem_q & ~found_mask) == '0);

  // Scan sequencer: accept, drain on handshake, abort back to idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      beat_q  <= '0;
`ifdef SCAN_TOTAL_EN
      total_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Abort is ignored here; an offered mask is still taken.
          if (bus.in_valid) begin
            rem_q   <= bus.in_mask;
            beat_q  <= '0;
            state_q <= StScan;
`ifdef SCAN_TOTAL_EN
            total_q <= '0;
`endif
          end
        end
        StScan: begin
          // Abort outranks a simultaneous handshake.
          if (bus.abort) begin
            state_q <= StIdle;
            rem_q   <= '0;
            beat_q  <= '0;
          end else if (bus.out_ready) begin
            rem_q  <= rem_q & ~found_mask;
            beat_q <= beat_q + BeatW'(1);
`ifdef SCAN_TOTAL_EN
            total_q <= total_q + 8'(lane_cnt);
`endif
            if (last_beat) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs gated by state so idle always shows reset values.
  assign bus.in_ready  = !scanning;
  assign bus.busy      = scanning;
  assign bus.out_valid = scanning;
  assign bus.out_idx1  = scanning ? lane_idx[0] : '0;
  assign bus.out_idx2  = scanning ? lane_idx[1] : '0;
  assign bus.out_idx3  = scanning ? lane_idx[2] : '0;
  assign bus.out_idx4  = scanning ? lane_idx[3] : '0;
  assign bus.out_cnt   = scanning ? lane_cnt : '0;
  assign bus.out_last  = scanning && last_beat;
  assign bus.beat_num  = scanning ? beat_q : '0;
`ifdef SCAN_TOTAL_EN
  assign bus.total_cnt = total_q;
`endif

endmodule
